// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch control in front of the instruction memory.
//
// The block holds the PC and drives its low bits to the instruction memory as a byte
// address. The returned word goes to decode over a valid/ready handshake, together
// with its PC. Execute can redirect fetch. A redirect to a misaligned target stops
// fetch in a sticky trap that only reset clears.
//
// Optional feature, selected by the FETCH_PERF_CNT_EN macro:
//   defined   -> adds the perf_fetch_o and perf_stall_o counters and their ports
//   undefined -> no counters; all other behaviour is the same
//
// Ports:
//   clk            core clock; all state changes on the rising edge
//   rst            synchronous, active-high reset
//   imem_addr_o    byte address to instruction memory (pc_q[IMEM_AW-1:0])
//   imem_inst_i    instruction word for imem_addr_o, returned in the same cycle
//   redirect_i     taken branch/jump this cycle
//   redirect_pc_i  redirect target byte address
//   inst_o         instruction to decode
//   pc_o           PC of inst_o
//   valid_o        inst_o/pc_o valid
//   ready_i        decode accepts inst_o this cycle
//   trap_o         sticky misaligned-fetch trap
//   trap_pc_o      offending target address, held while trap_o=1
//   perf_fetch_o   (FETCH_PERF_CNT_EN) accepted-fetch cycle count
//   perf_stall_o   (FETCH_PERF_CNT_EN) stalled-fetch cycle count
//
// State | Meaning
// ------+---------------------------------------------------------------
// BOOT  | first cycle after reset; memory gets one clean cycle, valid_o=0
// RUN   | fetching; inst_o/pc_o presented to decode with valid_o=1
// TRAP  | misaligned redirect seen; fetch stopped until reset
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [31:0]        imem_inst_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic [31:0]        inst_o,
    output logic [31:0]        pc_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               trap_o,
    output logic [31:0]        trap_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_o,
    output logic [31:0]        perf_stall_o
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] trap_pc_q;
    logic [31:0] trap_pc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            pc_q      <= RESET_PC;
            trap_pc_q <= 32'd0;
        end else begin
            state     <= state_next;
            pc_q      <= pc_next;
            trap_pc_q <= trap_pc_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc_q;
        trap_pc_next = trap_pc_q;
        valid_o      = 1'b0;
        trap_o       = 1'b0;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                valid_o = 1'b1;
                if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
                    state_next   = TRAP;
                    trap_pc_next = redirect_pc_i;
                end else if (redirect_i) begin
                    // The instruction shown this cycle is squashed; decode drops it.
                    pc_next = redirect_pc_i;
                end else if (ready_i) begin
                    pc_next = pc_q + 32'd4;
                end
            end
            TRAP: begin
                trap_o = 1'b1;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // The memory does the word indexing; the address wraps modulo 2^IMEM_AW.
    assign imem_addr_o = pc_q[IMEM_AW-1:0];
    assign inst_o      = imem_inst_i;
    assign pc_o        = pc_q;
    assign trap_pc_o   = trap_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;
    logic        fetch_hit;
    logic        stall_hit;

    // Redirect cycles count as neither an accepted fetch nor a stall.
    assign fetch_hit = (state == RUN) && ready_i && !redirect_i;
    assign stall_hit = (state == RUN) && !ready_i && !redirect_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (fetch_hit) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (stall_hit) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule
